// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write controller: frame layout,
// FSM states and the peripheral register map.
package spi_pkg;

    localparam int unsigned FRAME_W   = 16;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = 4;

    localparam logic WRITE_FLAG = 1'b1;

    localparam logic [ADDR_W-1:0] EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } spi_state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

    function automatic spi_frame_t build_frame(input logic [ADDR_W-1:0] addr,
                                               input logic [DATA_W-1:0] data);
        spi_frame_t f;
        f.wr   = WRITE_FLAG;
        f.addr = addr;
        f.data = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_tick.sv
// Half-period timer: one-cycle tick every HALF_PERIOD enabled cycles,
// restarted from zero whenever clr is asserted.
module spi_tick #(
    parameter int unsigned HALF_PERIOD = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(HALF_PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_c = en && (cnt == LAST);

    // Wraps on the tick so every state entered on a tick starts from zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller: shifts {write flag, addr, data} MSB first
// with framed chip select and a one-cycle done pulse per completed frame.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              done,
    output logic              ncs,
    output logic              sclk,
    output logic              copi
);

    spi_state_t           state;
    logic [FRAME_W-2:0]   shift;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [FRAME_W-1:0]   frame_c;
    logic                 accept_c;
    logic                 tick_en_c;
    logic                 tick_c;

    assign frame_c   = build_frame(addr, data);
    assign accept_c  = start && ready;
    assign tick_en_c = (state != IDLE);

    spi_tick #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (tick_en_c),
        .clr    (accept_c),
        .tick_c (tick_c)
    );

    // copi is only updated on ncs fall or sclk fall; shift holds the bits still to send.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            ncs     <= 1'b1;
            sclk    <= 1'b0;
            copi    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        shift   <= frame_c[FRAME_W-2:0];
                        copi    <= frame_c[FRAME_W-1];
                        bit_cnt <= '0;
                        ncs     <= 1'b0;
                        ready   <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick_c) begin
                        sclk  <= 1'b1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick_c) begin
                        sclk <= 1'b0;
                        if (bit_cnt == BIT_CNT_W'(FRAME_W - 1)) begin
                            copi  <= 1'b0;
                            state <= HOLD;
                        end else begin
                            copi    <= shift[FRAME_W-2];
                            shift   <= {shift[FRAME_W-3:0], 1'b0};
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            state   <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (tick_c) begin
                        sclk  <= 1'b1;
                        state <= HIGH;
                    end
                end
                HOLD: begin
                    if (tick_c) begin
                        ncs   <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tick_c) begin
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    ncs   <= 1'b1;
                    sclk  <= 1'b0;
                    copi  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 50, meaning clk cycles per SCLK half-period (10 MHz clk gives 100 kHz SCLK); legal range 4..1023.
REQ-002 SHALL have port clk  input  1  system clock (10 MHz); the block SHALL use one clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a write frame; qualified by ready.
REQ-005 SHALL have port addr  input  7  target register address.
REQ-006 SHALL have port data  input  8  register write data.
REQ-007 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-008 SHALL have port done  output  1  one-cycle pulse when a frame completes.
REQ-009 SHALL have port ncs  output  1  chip select, active low.
REQ-010 SHALL have port sclk  output  1  SPI clock, mode 0 (idle low).
REQ-011 SHALL have port copi  output  1  controller-out peripheral-in serial data.

Function
REQ-012 SHALL transmit a 16-bit frame {1'b1 write flag, addr[6:0], data[7:0]}, MSB first.
REQ-013 SHALL accept a request only in the cycle where start && ready, latching addr and data that cycle; start while ready=0 SHALL be ignored.
REQ-014 SHALL implement states IDLE, SETUP, HIGH, LOW, HOLD, GAP; ready=1 only in IDLE.
REQ-015 IDLE: ncs=1, sclk=0, copi=0; on accept, in the next cycle ncs=0, copi=frame[15], enter SETUP.
REQ-016 SETUP: SHALL hold sclk=0 for HALF_PERIOD cycles, then drive sclk=1 and enter HIGH.
REQ-017 HIGH: SHALL hold sclk=1 for HALF_PERIOD cycles, then drive sclk=0; if bit 15 has been sent, enter HOLD, else present the next bit on copi and enter LOW.
REQ-018 LOW: SHALL hold sclk=0 for HALF_PERIOD cycles, then drive sclk=1 and enter HIGH.
REQ-019 copi SHALL change only coincident with sclk falling or the ncs falling edge, never on the sclk rising edge.
REQ-020 HOLD: SHALL hold ncs=0, sclk=0 for HALF_PERIOD cycles, then drive ncs=1 and enter GAP.
REQ-021 GAP: SHALL hold ncs=1 for HALF_PERIOD cycles, then pulse done for exactly one cycle and return to IDLE with ready=1 in that same cycle.
REQ-022 ncs low time SHALL be exactly 33*HALF_PERIOD cycles; exactly 16 sclk rising edges SHALL occur per frame.
REQ-023 Back-to-back: start asserted in the done cycle SHALL be accepted, giving ncs high for at least HALF_PERIOD+1 cycles between frames.
REQ-024 Half-period counter SHALL be clog2(HALF_PERIOD) bits wide and the bit counter 4 bits wide; neither SHALL wrap within a frame.

Reset
REQ-025 rst=1 SHALL, in the next cycle, force IDLE with ncs=1, sclk=0, copi=0, done=0, ready=1, all counters and the shift register cleared.
REQ-026 rst asserted mid-frame SHALL abort the frame: ncs rises at once and done SHALL NOT pulse for the aborted frame.
REQ-027 start coincident with rst SHALL be ignored.

Structure
REQ-028 Package spi_pkg SHALL hold the frame width (16), the write-flag value, the state enum and the register address constants: EN_OUT_7_0=0x00, EN_OUT_15_8=0x01, EN_PWM_7_0=0x02, EN_PWM_15_8=0x03, PWM_DUTY=0x04.
REQ-029 A sub-module spi_tick (half-period counter producing a one-cycle tick every HALF_PERIOD cycles while enabled, cleared on state entry) SHALL be used; everything else resides in spi_controller.

Verification
REQ-030 Single write addr=0x04, data=0xA5 -> sampled on sclk rises copi=0x84A5 MSB first, 16 rises, ncs low 1650 cycles, one done pulse.
REQ-031 Loopback into the team's SPI peripheral, writes 0x00/0x3C then 0x01/0xC3 -> peripheral en-out register reads 0xC33C.
REQ-032 Back-to-back: start held high for three frames -> three done pulses, ncs high at least HALF_PERIOD+1 cycles between frames.
REQ-033 start pulsed during frame (ready=0) with addr=0x02 -> ignored; in-flight frame bits unchanged, single done.
REQ-034 rst asserted at the 8th sclk rise -> next cycle ncs=1, sclk=0, ready=1, no done; subsequent write 0x03/0xFF completes correctly.
REQ-035 HALF_PERIOD=4 -> ncs low 132 cycles, sclk high/low 4 cycles each, copi stable around every rise.
